m_issue_ctrl: RTL and testbench
===============================

# m_issue_ctrl

Issue controller sequencing the core's M-extension operations onto the shared multiply/divide unit. Accepts one RV32M request at a time from the execute stage over a valid/ready handshake and translates funct3 into the unit's 4-bit op code. Holds operands stable while the unit runs and returns the tagged result over a second valid/ready handshake. Also handles pipeline flush, a hang watchdog and an optional divide-by-zero fast path.

## Interface
- TAG_W, 4, width of request/response tag
- TIMEOUT, 64, max cycles in WAIT before watchdog abort (≥ 40)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept
- req_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
- req_rs1, req_rs2  in  32  operands
- req_tag  in  TAG_W  destination tag
- flush  in  1  kill the in-flight operation
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_data  out  32  result
- resp_tag  out  TAG_W  tag of result
- resp_err  out  1  watchdog abort, resp_data = 0
- m_op  out  4  unit op code
- m_a, m_b  out  32  unit operands
- m_kill  out  1  drives the unit's branch/kill input
- m_result  in  32  unit result
- m_done  in  1  unit result valid
- m_busy  in  1  unit busy
- busy  out  1  state ≠ IDLE

## Operation
- funct3 → m_op: 000→0001, 001→0010, 010→0100, 011→0011, 100→1000, 101→1001, 110→1010, 111→1011. m_op = 0000 whenever no op is issued.
- States:
  - IDLE: req_ready = 1. On req_valid, latch funct3/rs1/rs2/tag, go to ISSUE.
  - ISSUE: drive m_op/m_a/m_b for one cycle; m_done is ignored. Go to WAIT.
  - WAIT: hold m_op/m_a/m_b. On m_done = 1, capture m_result into resp_data and go to RESP. If the watchdog count reaches TIMEOUT, set resp_err = 1, resp_data = 0 and go to RESP.
  - RESP: resp_valid = 1, m_op = 0000. On resp_ready, go to IDLE.
- The unit always sees at least one cycle of m_op = 0000 between operations (RESP ≥ 1 cycle, then IDLE), guaranteeing a fresh start edge.
- Flush in ISSUE or WAIT: m_kill = 1 for that cycle, m_op = 0000 next cycle, result discarded, return to IDLE with no response.
- Flush in RESP: ignored; the response completes.
- Flush in IDLE: ignored.
- Flush and req_valid in the same IDLE cycle: the request is accepted.
- Watchdog: counter cleared on entering ISSUE, increments each WAIT cycle, saturates.
- Reset (any state): IDLE. req_ready = 1. resp_valid = 0, resp_err = 0, resp_data = 0, resp_tag = 0. m_op = 0000, m_a = m_b = 0, m_kill = 0, busy = 0.

## Timing
- Request accepted at edge N (req_valid & req_ready).
- ISSUE in cycle N+1; WAIT from N+2.
- m_done sampled high at edge M gives resp_valid high in cycle M+1.
- Minimum latency from accept to resp_valid is 3 cycles.
- Throughput: one op per (latency + 1) cycles minimum; no overlap.
- resp_data, resp_tag and resp_err are stable while resp_valid & !resp_ready.
- req_ready is low from the cycle after accept until the cycle after the response handshake.
- m_kill is asserted for exactly one cycle per flush.

## Configuration
- M_ZERO_BYPASS_EN defined:
  - In IDLE, a DIV/DIVU/REM/REMU request with rs2 = 0 bypasses the unit: straight to RESP, resp_valid in cycle N+1, m_op stays 0000.
  - Results per RISC-V: DIV/DIVU → 0xFFFF_FFFF; REM/REMU → rs1.
- M_ZERO_BYPASS_EN undefined:
  - Divide-by-zero requests take the normal ISSUE/WAIT path.
  - Result is whatever the unit returns.

## Test plan
- MUL, rs1 = 7, rs2 = −3 (0xFFFF_FFFD), tag 5 → m_op = 0001 during ISSUE/WAIT; resp_data = 0xFFFF_FFEB, resp_tag = 5, resp_err = 0.
- DIVU 100 / 7, resp_ready held low 3 cycles after resp_valid → resp_data = 14 stable for all 4 cycles; req_ready low until the cycle after the handshake.
- REM 0x8000_0001 / 3 with flush asserted 5 cycles into WAIT → m_kill pulses 1 cycle, no resp_valid, back to IDLE; a following MULHU 0xFFFF_FFFF × 2 returns 1.
- m_done forced low, TIMEOUT = 64 → resp_valid after 64 WAIT cycles, resp_err = 1, resp_data = 0.
- DIV 5 / 0 → with M_ZERO_BYPASS_EN: resp_data = 0xFFFF_FFFF at N+1, m_op never leaves 0000. Without the macro: normal path latency.
- rst_n low in WAIT → next cycle IDLE, m_op = 0000, resp_valid = 0; a new request issues cleanly.

Source files
------------

// File: rtl/m_issue_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : m_issue_ctrl_if
// Brief   : Request, response and mul/div unit signals of the M-extension
//           issue controller; slave = controller, master = its surroundings.
// Revision: 1.0
// ============================================================================
interface m_issue_ctrl_if #(
    parameter int TAG_W = 4
) ();
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_funct3;
    logic [31:0]      req_rs1;
    logic [31:0]      req_rs2;
    logic [TAG_W-1:0] req_tag;
    logic             flush;
    logic             resp_valid;
    logic             resp_ready;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic [3:0]       m_op;
    logic [31:0]      m_a;
    logic [31:0]      m_b;
    logic             m_kill;
    logic [31:0]      m_result;
    logic             m_done;
    logic             m_busy;
    logic             busy;

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
        input  resp_ready, m_result, m_done, m_busy,
        output req_ready, resp_valid, resp_data, resp_tag, resp_err,
        output m_op, m_a, m_b, m_kill, busy
    );

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_tag, flush,
        output resp_ready, m_result, m_done, m_busy,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_err,
        input  m_op, m_a, m_b, m_kill, busy
    );
endinterface
`default_nettype wire

// File: rtl/m_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : m_issue_ctrl
// Brief   : Issues one RV32M op at a time to the shared mul/div unit, with
//           flush, hang watchdog and (macro M_ZERO_BYPASS_EN) a div-by-zero
//           fast path that answers without touching the unit.
// Revision: 1.0
// ============================================================================
module m_issue_ctrl #(
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 64
) (
    input  wire                clk,
    input  wire                rst_n,
    m_issue_ctrl_if.slave      bus
);

    localparam int c_WD_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT - 1);
    localparam logic [c_WD_W-1:0] c_WD_MAX  = {c_WD_W{1'b1}};
    localparam logic [c_WD_W-1:0] c_WD_ONE  = c_WD_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_req_ready;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic               r_busy;
    logic [31:0]        r_resp_data;
    logic [TAG_W-1:0]   r_resp_tag;
    logic [TAG_W-1:0]   r_tag;
    logic [3:0]         r_m_op;
    logic [31:0]        r_m_a;
    logic [31:0]        r_m_b;
    logic [c_WD_W-1:0]  r_wd_cnt;

    logic               w_bypass;
    logic [31:0]        w_zero_res;
    logic               w_wd_hit;
    logic               w_unused;

    function automatic logic [3:0] f_decode(input logic [2:0] f3);
        logic [3:0] op;
        op = 4'b0000;
        case (f3)
            3'b000:  op = 4'b0001;
            3'b001:  op = 4'b0010;
            3'b010:  op = 4'b0100;
            3'b011:  op = 4'b0011;
            3'b100:  op = 4'b1000;
            3'b101:  op = 4'b1001;
            3'b110:  op = 4'b1010;
            3'b111:  op = 4'b1011;
            default: op = 4'b0000;
        endcase
        return op;
    endfunction

`ifdef M_ZERO_BYPASS_EN
    assign w_bypass = bus.req_funct3[2] && (bus.req_rs2 == 32'd0);
`else
    assign w_bypass = 1'b0;
`endif

    // RISC-V divide-by-zero: quotient all ones, remainder = dividend
    assign w_zero_res = bus.req_funct3[1] ? bus.req_rs1 : 32'hFFFF_FFFF;
    assign w_wd_hit   = (r_wd_cnt == c_WD_LAST);
    assign w_unused   = bus.m_busy;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_busy       <= 1'b0;
            r_resp_data  <= 32'd0;
            r_resp_tag   <= '0;
            r_tag        <= '0;
            r_m_op       <= 4'b0000;
            r_m_a        <= 32'd0;
            r_m_b        <= 32'd0;
            r_wd_cnt     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (w_bypass) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b0;
                            r_resp_data  <= w_zero_res;
                            r_resp_tag   <= bus.req_tag;
                        end else begin
                            r_state  <= S_ISSUE;
                            r_m_op   <= f_decode(bus.req_funct3);
                            r_m_a    <= bus.req_rs1;
                            r_m_b    <= bus.req_rs2;
                            r_tag    <= bus.req_tag;
                            r_wd_cnt <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    if (bus.flush) begin
                        r_state     <= S_IDLE;
                        r_m_op      <= 4'b0000;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.flush) begin
                        r_state     <= S_IDLE;
                        r_m_op      <= 4'b0000;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end else if (bus.m_done || w_wd_hit) begin
                        // a late m_done in the abort cycle still wins
                        r_state      <= S_RESP;
                        r_m_op       <= 4'b0000;
                        r_resp_valid <= 1'b1;
                        r_resp_tag   <= r_tag;
                        r_resp_err   <= !bus.m_done;
                        r_resp_data  <= bus.m_done ? bus.m_result : 32'd0;
                    end else if (r_wd_cnt != c_WD_MAX) begin
                        r_wd_cnt <= r_wd_cnt + c_WD_ONE;
                    end
                end
                S_RESP: begin
                    if (bus.resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_busy       <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready  = r_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_data  = r_resp_data;
    assign bus.resp_tag   = r_resp_tag;
    assign bus.resp_err   = r_resp_err;
    assign bus.m_op       = r_m_op;
    assign bus.m_a        = r_m_a;
    assign bus.m_b        = r_m_b;
    assign bus.busy       = r_busy;
    // kill must reach the unit in the same cycle the flush is seen
    assign bus.m_kill     = bus.flush && ((r_state == S_ISSUE) || (r_state == S_WAIT));

endmodule
`default_nettype wire

// File: tb/tb_m_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_m_issue_ctrl
// Brief   : Directed self-checking bench for m_issue_ctrl with a behavioural
//           mul/div unit stub.
// Revision: 1.0
// ============================================================================
module tb_m_issue_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_mis;
    int   unit_lat;
    bit   unit_hang;
    int   u_cnt;
    logic [3:0]  u_op;
    logic [3:0]  u_prev;
    logic [31:0] u_a;
    logic [31:0] u_b;

    m_issue_ctrl_if #(.TAG_W(4)) bus ();

    m_issue_ctrl #(.TAG_W(4), .TIMEOUT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] unit_calc(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] r;
        r = 32'd0;
        case (op)
            4'b0001: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            4'b0010: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[63:32]; end
            4'b0100: begin p = $signed({{32{a[31]}}, a}) * $signed({32'd0, b}); r = p[63:32]; end
            4'b0011: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
            4'b1000: r = (b == 0) ? 32'hFFFF_FFFF :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : $signed(a) / $signed(b);
            4'b1001: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'b1010: r = (b == 0) ? a :
                         (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : $signed(a) % $signed(b);
            4'b1011: r = (b == 0) ? a : a % b;
            default: r = 32'hDEAD_BEEF;
        endcase
        return r;
    endfunction

    // unit stub: starts on an m_op rising from zero, answers after unit_lat cycles
    always @(negedge clk) begin
        bus.m_done = 1'b0;
        if (!rst_n || bus.m_kill) begin
            u_cnt = 0;
            if (!rst_n) bus.m_result = 32'd0;
        end else if (bus.m_op != 4'd0 && u_prev == 4'd0) begin
            u_cnt = unit_lat;
            u_op  = bus.m_op;
            u_a   = bus.m_a;
            u_b   = bus.m_b;
        end else if (u_cnt > 0) begin
            u_cnt = u_cnt - 1;
            if (u_cnt == 0 && !unit_hang) begin
                bus.m_done   = 1'b1;
                bus.m_result = unit_calc(u_op, u_a, u_b);
            end
        end
        bus.m_busy = (u_cnt != 0);
        u_prev     = bus.m_op;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [3:0] tag);
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_tag    = tag;
        bus.req_valid  = 1'b1;
        check("req_ready_before_accept", bus.req_ready, 1);
        cyc();
        bus.req_valid  = 1'b0;
    endtask

    task automatic wait_resp(input int max, output int k);
        k = 0;
        while (!bus.resp_valid && k < max) begin
            cyc();
            k++;
        end
        check("resp_valid_seen", bus.resp_valid, 1);
    endtask

    task automatic handshake();
        bus.resp_ready = 1'b1;
        cyc();
        bus.resp_ready = 1'b0;
        check("post_hs_resp_valid", bus.resp_valid, 0);
        check("post_hs_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int k;
        int seen;
        int exp_k;
        logic [3:0] exp_op;
        n_cmp = 0;
        n_mis = 0;
        unit_lat  = 1;
        unit_hang = 1'b0;
        u_cnt  = 0;
        u_prev = 4'd0;
        rst_n  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_rs1    = 32'd0;
        bus.req_rs2    = 32'd0;
        bus.req_tag    = 4'd0;
        bus.flush      = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (3) cyc();

        check("rst_req_ready", bus.req_ready, 1);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_resp_err", bus.resp_err, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_tag", bus.resp_tag, 0);
        check("rst_m_op", bus.m_op, 0);
        check("rst_m_a", bus.m_a, 0);
        check("rst_m_kill", bus.m_kill, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        cyc();

        // MUL 7 * -3
        unit_lat = 3;
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 4'd5);
        check("mul_issue_op", bus.m_op, 4'b0001);
        check("mul_issue_a", bus.m_a, 7);
        check("mul_req_ready", bus.req_ready, 0);
        check("mul_busy", bus.busy, 1);
        cyc();
        check("mul_wait_op", bus.m_op, 4'b0001);
        wait_resp(20, k);
        check("mul_latency", k, 3);
        check("mul_data", bus.resp_data, 32'hFFFF_FFEB);
        check("mul_tag", bus.resp_tag, 5);
        check("mul_err", bus.resp_err, 0);
        check("mul_resp_op", bus.m_op, 0);
        handshake();
        check("mul_idle_busy", bus.busy, 0);

        // DIVU 100/7, minimum latency, back-pressure, flush ignored in RESP
        unit_lat = 1;
        issue(3'b101, 32'd100, 32'd7, 4'd10);
        wait_resp(20, k);
        check("divu_latency", k, 2);
        for (int i = 0; i < 4; i++) begin
            check("divu_hold_data", bus.resp_data, 14);
            check("divu_hold_valid", bus.resp_valid, 1);
            check("divu_hold_req_ready", bus.req_ready, 0);
            if (i == 1) begin
                bus.flush = 1'b1;
                #1;
                check("divu_resp_kill", bus.m_kill, 0);
            end
            if (i == 2) bus.flush = 1'b0;
            if (i < 3) cyc();
        end
        check("divu_tag", bus.resp_tag, 10);
        handshake();

        // REM killed in WAIT, then MULHU
        unit_lat = 20;
        issue(3'b110, 32'h8000_0001, 32'd3, 4'd7);
        repeat (5) cyc();
        check("rem_wait_op", bus.m_op, 4'b1010);
        bus.flush = 1'b1;
        #1;
        check("rem_kill_high", bus.m_kill, 1);
        cyc();
        bus.flush = 1'b0;
        #1;
        check("rem_kill_low", bus.m_kill, 0);
        check("rem_flush_op", bus.m_op, 0);
        check("rem_flush_req_ready", bus.req_ready, 1);
        check("rem_flush_busy", bus.busy, 0);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.resp_valid) seen++;
            cyc();
        end
        check("rem_no_resp", seen, 0);
        unit_lat = 2;
        issue(3'b011, 32'hFFFF_FFFF, 32'd2, 4'd1);
        wait_resp(20, k);
        check("mulhu_data", bus.resp_data, 1);
        check("mulhu_tag", bus.resp_tag, 1);
        handshake();

        // watchdog abort
        unit_hang = 1'b1;
        issue(3'b000, 32'd3, 32'd4, 4'd9);
        wait_resp(100, k);
        check("wd_latency", k, 65);
        check("wd_err", bus.resp_err, 1);
        check("wd_data", bus.resp_data, 0);
        check("wd_tag", bus.resp_tag, 9);
        handshake();
        unit_hang = 1'b0;

        // divide by zero
`ifdef M_ZERO_BYPASS_EN
        exp_k = 0;
`else
        exp_k = 3;
`endif
        unit_lat = 2;
        issue(3'b100, 32'd5, 32'd0, 4'd3);
`ifdef M_ZERO_BYPASS_EN
        exp_op = 4'b0000;
`else
        exp_op = 4'b1000;
`endif
        check("div0_op", bus.m_op, exp_op);
        wait_resp(20, k);
        check("div0_latency", k, exp_k);
        check("div0_data", bus.resp_data, 32'hFFFF_FFFF);
        check("div0_tag", bus.resp_tag, 3);
        check("div0_err", bus.resp_err, 0);
        handshake();
        issue(3'b111, 32'd9, 32'd0, 4'd4);
        wait_resp(20, k);
        check("remu0_latency", k, exp_k);
        check("remu0_data", bus.resp_data, 9);
        handshake();

        // reset while in WAIT
        unit_lat = 10;
        issue(3'b001, 32'd1, 32'd1, 4'd6);
        cyc();
        cyc();
        rst_n = 1'b0;
        cyc();
        check("wrst_resp_valid", bus.resp_valid, 0);
        check("wrst_m_op", bus.m_op, 0);
        check("wrst_req_ready", bus.req_ready, 1);
        check("wrst_busy", bus.busy, 0);
        check("wrst_resp_tag", bus.resp_tag, 0);
        check("wrst_m_a", bus.m_a, 0);
        rst_n = 1'b1;
        cyc();

        // flush with a request in IDLE: request is accepted
        unit_lat = 1;
        bus.flush = 1'b1;
        issue(3'b000, 32'd6, 32'd7, 4'd2);
        bus.flush = 1'b0;
        #1;
        check("idle_flush_busy", bus.busy, 1);
        check("idle_flush_op", bus.m_op, 4'b0001);
        check("idle_flush_kill", bus.m_kill, 0);
        wait_resp(20, k);
        check("after_rst_latency", k, 2);
        check("after_rst_data", bus.resp_data, 42);
        check("after_rst_tag", bus.resp_tag, 2);
        check("after_rst_err", bus.resp_err, 0);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
`default_nettype wire
